cbfp0_shift_apply: RTL and testbench

Downstream partner of the CBFP stage-0 min-shift window. It buffers one 32-sample block of complex butterfly output in a ping-pong bank while the minimum-shift search runs. Once that block's min_shift is delivered, it reads the block back, normalises every sample by the common shift, saturates to the output width and streams the result. It also emits the applied shift index so the later denormalisation stage can undo it.

---
 rtl/cbfp0_shift_apply_if.sv | 36 +++
 rtl/cbfp0_shift_apply.sv | 188 ++++++++++++++++++
 tb/tb_cbfp0_shift_apply.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/cbfp0_shift_apply_if.sv
// Sample, shift and status bundle between the CBFP stage-0 butterfly
// side and the shift-apply block.
interface cbfp0_shift_apply_if #(
   parameter int DW = 13,
   parameter int OW = 11,
   parameter int SW = 5
);
   logic                 din_valid;
   logic signed [DW-1:0] din_re;
   logic signed [DW-1:0] din_im;
   logic                 min_valid;
   logic [SW-1:0]        min_shift;
   logic                 dout_valid;
   logic signed [OW-1:0] dout_re;
   logic signed [OW-1:0] dout_im;
   logic [SW-1:0]        dout_shift;
   logic                 blk_first;
   logic                 err_ovf;
   logic                 err_spur;

   modport master (
      output din_valid, din_re, din_im,
      output min_valid, min_shift,
      input  dout_valid, dout_re, dout_im,
      input  dout_shift, blk_first,
      input  err_ovf, err_spur
   );

   modport slave (
      input  din_valid, din_re, din_im,
      input  min_valid, min_shift,
      output dout_valid, dout_re, dout_im,
      output dout_shift, blk_first,
      output err_ovf, err_spur
   );
endinterface

// File: rtl/cbfp0_shift_apply.sv
// Ping-pong block buffer that applies the CBFP stage-0 common shift,
// saturates to the output width and streams the normalised block.
module cbfp0_shift_apply #(
   parameter int DW  = 13,
   parameter int OW  = 11,
   parameter int SW  = 5,
   parameter int BLK = 32
) (
   input logic clk,
   input logic rstn,
   cbfp0_shift_apply_if.slave io
);

   localparam int AW = $clog2(BLK);
   localparam int IW = 2 * DW - 1;
   localparam logic [AW-1:0] LAST = AW'(BLK - 1);
   localparam logic [SW-1:0] SMAX = SW'(DW - 1);
   localparam logic signed [IW-1:0] OMAX = IW'(2 ** (OW - 1) - 1);
   localparam logic signed [IW-1:0] OMIN = ~OMAX;

   typedef enum logic {IDLE, READ} state_e;

   function automatic logic [SW-1:0] clamp(input logic [SW-1:0] s);
      return (s > SMAX) ? SMAX : s;
   endfunction

   function automatic logic signed [OW-1:0] norm(
      input logic signed [DW-1:0] x,
      input logic [SW-1:0]        s
   );
      logic signed [IW-1:0] w;
      w = {{(IW - DW){x[DW-1]}}, x};
      w = w <<< s;
      w = w >>> (DW - OW);
      if (w > OMAX) return OMAX[OW-1:0];
      if (w < OMIN) return OMIN[OW-1:0];
      return w[OW-1:0];
   endfunction

   logic signed [DW-1:0] mem_re_q [2][BLK];
   logic signed [DW-1:0] mem_im_q [2][BLK];

   state_e        state_q, state_d;
   logic [AW-1:0] wcnt_q, wcnt_d;
   logic [AW-1:0] rcnt_q, rcnt_d;
   logic          wb_q, wb_d;
   logic          rb_q, rb_d;
   logic          drop_q, drop_d;
   logic [1:0]    full_q, full_d;
   logic [1:0]    hs_q, hs_d;
   logic [SW-1:0] sh_q [2];
   logic [SW-1:0] sh_d [2];
   logic          ovf_q, ovf_d;
   logic          spur_q, spur_d;

   logic                 dv_q, dv_d;
   logic signed [OW-1:0] re_q, re_d;
   logic signed [OW-1:0] im_q, im_d;
   logic [SW-1:0]        dsh_q, dsh_d;
   logic                 first_q, first_d;

   logic          free_now, wr_last, ovf_now, wr_drop, wr_en;
   logic [1:0]    fe, hs_e, rdy;
   logic [SW-1:0] sh_e [2];
   logic          min_rb, min_ot, spur_now, rd_en;

   // Bank views as they stand after this cycle's write and min_valid.
   always_comb begin
      free_now = (state_q == READ) && (rcnt_q == LAST);
      wr_last  = io.din_valid && (wcnt_q == LAST);
      ovf_now  = io.din_valid && (wcnt_q == '0) && full_q[wb_q] &&
                 !(free_now && (rb_q == wb_q));
      wr_drop  = (wcnt_q == '0) ? ovf_now : drop_q;
      wr_en    = io.din_valid && !wr_drop;
      fe = full_q;
      if (wr_en && wr_last) fe[wb_q] = 1'b1;
      min_rb   = io.min_valid && fe[rb_q] && !hs_q[rb_q];
      min_ot   = io.min_valid && !min_rb &&
                 fe[~rb_q] && !hs_q[~rb_q];
      spur_now = io.min_valid && !min_rb && !min_ot;
      hs_e = hs_q;
      sh_e = sh_q;
      if (min_rb) begin
         hs_e[rb_q] = 1'b1;
         sh_e[rb_q] = clamp(io.min_shift);
      end
      if (min_ot) begin
         hs_e[~rb_q] = 1'b1;
         sh_e[~rb_q] = clamp(io.min_shift);
      end
      rdy = fe & hs_e;
   end

   always_comb begin
      wcnt_d = wcnt_q;
      wb_d   = wb_q;
      drop_d = drop_q;
      ovf_d  = ovf_q | ovf_now;
      spur_d = spur_q | spur_now;
      if (io.din_valid) begin
         wcnt_d = wcnt_q + AW'(1);
         drop_d = wr_drop && !wr_last;
         if (wr_en && wr_last) wb_d = ~wb_q;
      end
   end

   // Reading starts in the cycle the oldest bank becomes ready.
   always_comb begin
      state_d = state_q;
      rcnt_d  = rcnt_q;
      rb_d    = rb_q;
      full_d  = fe;
      hs_d    = hs_e;
      sh_d    = sh_e;
      rd_en   = (state_q == READ) || rdy[rb_q];
      if (rd_en) begin
         if (rcnt_q == LAST) begin
            rcnt_d       = '0;
            rb_d         = ~rb_q;
            full_d[rb_q] = 1'b0;
            hs_d[rb_q]   = 1'b0;
            state_d      = rdy[~rb_q] ? READ : IDLE;
         end else begin
            rcnt_d  = rcnt_q + AW'(1);
            state_d = READ;
         end
      end
      dv_d    = rd_en;
      first_d = rd_en && (rcnt_q == '0);
      dsh_d   = rd_en ? sh_e[rb_q] : '0;
      re_d    = rd_en ? norm(mem_re_q[rb_q][rcnt_q], sh_e[rb_q]) : '0;
      im_d    = rd_en ? norm(mem_im_q[rb_q][rcnt_q], sh_e[rb_q]) : '0;
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_re_q[wb_q][wcnt_q] <= io.din_re;
         mem_im_q[wb_q][wcnt_q] <= io.din_im;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= IDLE;
         wcnt_q  <= '0;
         rcnt_q  <= '0;
         wb_q    <= 1'b0;
         rb_q    <= 1'b0;
         drop_q  <= 1'b0;
         full_q  <= '0;
         hs_q    <= '0;
         sh_q    <= '{default: '0};
         ovf_q   <= 1'b0;
         spur_q  <= 1'b0;
         dv_q    <= 1'b0;
         re_q    <= '0;
         im_q    <= '0;
         dsh_q   <= '0;
         first_q <= 1'b0;
      end else begin
         state_q <= state_d;
         wcnt_q  <= wcnt_d;
         rcnt_q  <= rcnt_d;
         wb_q    <= wb_d;
         rb_q    <= rb_d;
         drop_q  <= drop_d;
         full_q  <= full_d;
         hs_q    <= hs_d;
         sh_q    <= sh_d;
         ovf_q   <= ovf_d;
         spur_q  <= spur_d;
         dv_q    <= dv_d;
         re_q    <= re_d;
         im_q    <= im_d;
         dsh_q   <= dsh_d;
         first_q <= first_d;
      end
   end

   assign io.dout_valid = dv_q;
   assign io.dout_re    = re_q;
   assign io.dout_im    = im_q;
   assign io.dout_shift = dsh_q;
   assign io.blk_first  = first_q;
   assign io.err_ovf    = ovf_q;
   assign io.err_spur   = spur_q;

endmodule

// File: tb/tb_cbfp0_shift_apply.sv
// Scoreboard bench for cbfp0_shift_apply: directed blocks with
// hand-computed normalised outputs checked by a negedge monitor.
module tb_cbfp0_shift_apply;

   typedef struct {
      int re;
      int im;
      int sh;
      int first;
   } exp_t;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   int   checks = 0;
   int   errors = 0;
   int   run = 0;
   int   last_run = 0;
   bit   ignore = 1'b0;
   exp_t sb[$];
   exp_t e;

   cbfp0_shift_apply_if #(.DW(13), .OW(11), .SW(5)) io ();

   cbfp0_shift_apply #(.DW(13), .OW(11), .SW(5), .BLK(32)) dut (
      .clk  (clk),
      .rstn (rstn),
      .io   (io)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", nm, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_block(input int re, input int im);
      for (int i = 0; i < 32; i++) begin
         io.din_valid = 1'b1;
         io.din_re    = 13'(re);
         io.din_im    = 13'(im);
         tick();
      end
      io.din_valid = 1'b0;
   endtask

   task automatic pulse_min(input int s);
      io.min_valid = 1'b1;
      io.min_shift = 5'(s);
      tick();
      io.min_valid = 1'b0;
   endtask

   task automatic push_exp(input int re, input int im, input int sh);
      for (int i = 0; i < 32; i++)
         sb.push_back('{re, im, sh, (i == 0) ? 1 : 0});
   endtask

   task automatic drain(input string nm);
      int n = 0;
      while (sb.size() != 0 && n < 400) begin
         tick();
         n++;
      end
      chk({nm, "_drain_left"}, sb.size(), 0);
      repeat (3) tick();
   endtask

   always @(negedge clk) begin
      if (!rstn) begin
         run = 0;
      end else if (io.dout_valid) begin
         run++;
         if (!ignore) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_out actual re=%0d required none",
                        io.dout_re);
            end else begin
               e = sb.pop_front();
               chk("dout_re", int'(io.dout_re), e.re);
               chk("dout_im", int'(io.dout_im), e.im);
               chk("dout_shift", int'(io.dout_shift), e.sh);
               chk("blk_first", int'(io.blk_first), e.first);
            end
         end
      end else begin
         if (run != 0) last_run = run;
         run = 0;
         if (!ignore)
            chk("idle_zero", int'({io.dout_re, io.dout_im,
                                   io.dout_shift, io.blk_first}), 0);
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

   initial begin
      io.din_valid = 1'b0;
      io.din_re    = '0;
      io.din_im    = '0;
      io.min_valid = 1'b0;
      io.min_shift = '0;
      repeat (3) tick();
      chk("rst_valid", int'(io.dout_valid), 0);
      chk("rst_first", int'(io.blk_first), 0);
      chk("rst_ovf", int'(io.err_ovf), 0);
      chk("rst_spur", int'(io.err_spur), 0);
      rstn = 1'b1;
      repeat (2) tick();

      // basic block, min_valid one cycle after last write
      send_block(100, -5);
      push_exp(200, -10, 3);
      pulse_min(3);
      @(negedge clk);
      chk("lat_valid", int'(io.dout_valid), 1);
      chk("lat_first", int'(io.blk_first), 1);
      drain("basic");

      send_block(1000, -1000);
      push_exp(1023, -1024, 3);
      pulse_min(3);
      drain("sat");

      send_block(4, -5);
      push_exp(1, -2, 0);
      pulse_min(0);
      drain("floor");

      send_block(1, -1);
      push_exp(1023, -1024, 12);
      pulse_min(20);
      drain("clamp");

      // back-to-back blocks, second min lands with last write
      push_exp(5, -10, 1);
      push_exp(120, 28, 4);
      fork
         begin
            send_block(10, -20);
            send_block(30, 7);
         end
         begin
            repeat (32) tick();
            pulse_min(1);
            repeat (30) tick();
            pulse_min(4);
         end
      join
      drain("b2b");
      chk("b2b_run", last_run, 64);
      chk("b2b_ovf", int'(io.err_ovf), 0);

      // overflow: third block dropped
      send_block(40, -40);
      send_block(-8, 12);
      chk("ovf_before", int'(io.err_ovf), 0);
      send_block(77, 77);
      chk("ovf_set", int'(io.err_ovf), 1);
      push_exp(40, -40, 2);
      push_exp(-2, 3, 0);
      pulse_min(2);
      pulse_min(0);
      drain("ovf");
      chk("ovf_run", last_run, 64);
      chk("ovf_spur", int'(io.err_spur), 0);

      pulse_min(3);
      repeat (5) tick();
      chk("spur_set", int'(io.err_spur), 1);

      // reset in the middle of a read
      ignore = 1'b1;
      send_block(50, 50);
      pulse_min(1);
      repeat (10) tick();
      chk("pre_rst_valid", int'(io.dout_valid), 1);
      rstn = 1'b0;
      #1;
      chk("mid_rst_valid", int'(io.dout_valid), 0);
      chk("mid_rst_re", int'(io.dout_re), 0);
      chk("mid_rst_shift", int'(io.dout_shift), 0);
      chk("mid_rst_ovf", int'(io.err_ovf), 0);
      chk("mid_rst_spur", int'(io.err_spur), 0);
      repeat (2) tick();
      rstn = 1'b1;
      ignore = 1'b0;
      repeat (2) tick();
      send_block(-100, 60);
      push_exp(-800, 480, 5);
      pulse_min(5);
      drain("post_rst");
      chk("post_rst_run", last_run, 32);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
